tl_egress_reader: RTL and testbench

TL_EGRESS_READER -- requirements
Module: tl_egress_reader

---
 rtl/tl_egress_reader.sv | 162 ++++++++++++++++
 tb/tb_tl_egress_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_egress_reader.sv
// tl_egress_reader: round-robin drain of four egress FIFOs into one valid/ready output stream.
// Optional per-class delivery counters are built only when EGRESS_COUNT_EN is defined.
module tl_egress_reader #(
   parameter int unsigned WORD_SIZE  = 10,
   parameter int unsigned FIFO_UNITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [3:0]           fifo_empty,
   input  logic [WORD_SIZE-1:0] fifo_data_in0,
   input  logic [WORD_SIZE-1:0] fifo_data_in1,
   input  logic [WORD_SIZE-1:0] fifo_data_in2,
   input  logic [WORD_SIZE-1:0] fifo_data_in3,
   input  logic                 out_ready,
   input  logic                 count_req,
   input  logic [1:0]           count_idx,
   output logic [3:0]           fifo_rd,
   output logic [WORD_SIZE-1:0] out_data,
   output logic [1:0]           out_class,
   output logic                 out_valid,
   output logic                 idle_out,
   output logic [4:0]           count_out,
   output logic                 count_valid
);

   localparam int unsigned GrantW = $clog2(FIFO_UNITS);

   typedef enum logic [1:0] {StIdle, StRead, StCapture, StHold} state_e;

   state_e               state_q, state_d;
   logic [GrantW-1:0]    last_grant_q, last_grant_d;
   logic [WORD_SIZE-1:0] out_data_q, out_data_d;
   logic [GrantW-1:0]    out_class_q, out_class_d;

   logic [GrantW-1:0]    pick;
   logic [GrantW-1:0]    cand;
   logic                 pick_found;
   logic [WORD_SIZE-1:0] rd_data;

   // Round-robin search starting one past the last grant; the last grant itself is tried last.
   always_comb begin
      pick       = last_grant_q;
      pick_found = 1'b0;
      cand       = '0;
      for (int k = 1; k <= int'(FIFO_UNITS); k++) begin
         cand = last_grant_q + GrantW'(k);
         if (!pick_found && !fifo_empty[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = fifo_data_in0;
      case (last_grant_q)
         2'd1:    rd_data = fifo_data_in1;
         2'd2:    rd_data = fifo_data_in2;
         2'd3:    rd_data = fifo_data_in3;
         default: rd_data = fifo_data_in0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= GrantW'(FIFO_UNITS - 1);
         out_data_q   <= '0;
         out_class_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         out_data_q   <= out_data_d;
         out_class_q  <= out_class_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      out_data_d   = out_data_q;
      out_class_d  = out_class_q;
      unique case (state_q)
         StIdle: begin
            if (enable && pick_found) begin
               state_d      = StRead;
               last_grant_d = pick;
            end
         end
         StRead: state_d = StCapture;
         StCapture: begin
            // FIFO read data is valid the cycle after the strobe.
            state_d     = StHold;
            out_data_d  = rd_data;
            out_class_d = last_grant_q;
         end
         StHold: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      fifo_rd   = '0;
      out_valid = 1'b0;
      idle_out  = 1'b0;
      unique case (state_q)
         StIdle:    idle_out  = &fifo_empty;
         StRead:    fifo_rd   = 4'b0001 << last_grant_q;
         StCapture: ;
         StHold:    out_valid = 1'b1;
         default:   ;
      endcase
   end

   assign out_data  = out_data_q;
   assign out_class = out_class_q;

`ifdef EGRESS_COUNT_EN
   logic [4:0] cnt_q [4];
   logic [4:0] cnt_d [4];
   logic [4:0] count_out_q, count_out_d;
   logic       count_valid_q, count_valid_d;

   // Reads see the pre-increment value because count_out_d samples cnt_q.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StHold && out_ready) begin
         cnt_d[out_class_q] = cnt_q[out_class_q] + 5'd1;
      end
      count_valid_d = count_req;
      count_out_d   = count_req ? cnt_q[count_idx] : 5'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         count_out_q   <= '0;
         count_valid_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         count_out_q   <= count_out_d;
         count_valid_q <= count_valid_d;
      end
   end

   assign count_out   = count_out_q;
   assign count_valid = count_valid_q;
`else
   logic unused_count;
   assign unused_count = ^{count_req, count_idx};
   assign count_out    = '0;
   assign count_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_tl_egress_reader.sv
// Randomized and directed bench for tl_egress_reader against a transaction-level model.
// Counter expectations follow EGRESS_COUNT_EN in the same way as the design build.
module tb_tl_egress_reader;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         reset, enable, out_ready, count_req;
   logic [3:0]   fifo_empty;
   logic [W-1:0] din [4];
   logic [1:0]   count_idx;
   logic [3:0]   fifo_rd;
   logic [W-1:0] out_data;
   logic [1:0]   out_class;
   logic         out_valid, idle_out, count_valid;
   logic [4:0]   count_out;

   always #5 clk = ~clk;

   tl_egress_reader #(.WORD_SIZE(W), .FIFO_UNITS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_data_in0(din[0]),
      .fifo_data_in1(din[1]),
      .fifo_data_in2(din[2]),
      .fifo_data_in3(din[3]),
      .out_ready    (out_ready),
      .count_req    (count_req),
      .count_idx    (count_idx),
      .fifo_rd      (fifo_rd),
      .out_data     (out_data),
      .out_class    (out_class),
      .out_valid    (out_valid),
      .idle_out     (idle_out),
      .count_out    (count_out),
      .count_valid  (count_valid)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [W-1:0] fq [4][$];

   // Transfer model: a word is "in flight" for read (age 0), capture (age 1), then hold (age >= 2).
   bit           m_busy;
   int           m_age;
   int           m_last;
   int           m_cls;
   logic [W-1:0] m_word;
   int           m_cnt [4];
   bit           m_cv;
   int           m_co;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int last);
      for (int k = 1; k <= 4; k++) begin
         if (fq[(last + k) % 4].size() != 0) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic refresh_empty();
      for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
   endtask

   task automatic push(input int i, input logic [W-1:0] w);
      fq[i].push_back(w);
      refresh_empty();
   endtask

   task automatic model_reset();
      m_busy = 0;
      m_age  = 0;
      m_last = 3;
      m_cls  = 0;
      m_cv   = 0;
      m_co   = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
   endtask

   // Called #1 after a rising edge with inputs applied; returns #1 after the next rising edge.
   task automatic tick();
      logic [3:0] rd_prev;
      int         pick;
      bit         nxt_cv;
      int         nxt_co;
      #1;
      check_val("fifo_rd", 32'(fifo_rd), (m_busy && m_age == 0) ? (32'd1 << m_cls) : 32'd0);
      check_val("out_valid", 32'(out_valid), 32'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
         check_val("out_data", 32'(out_data), 32'(m_word));
         check_val("out_class", 32'(out_class), 32'(m_cls));
      end
      check_val("idle_out", 32'(idle_out), 32'(!m_busy && fifo_empty == 4'hf));
`ifdef EGRESS_COUNT_EN
      check_val("count_valid", 32'(count_valid), 32'(m_cv));
      check_val("count_out", 32'(count_out), 32'(m_co));
`else
      check_val("count_valid", 32'(count_valid), 32'd0);
      check_val("count_out", 32'(count_out), 32'd0);
`endif
      rd_prev = fifo_rd;
      nxt_cv  = count_req;
      nxt_co  = count_req ? m_cnt[count_idx] : 0;
      if (!m_busy) begin
         pick = rr_pick(m_last);
         if (enable && pick >= 0) begin
            m_busy = 1;
            m_age  = 0;
            m_cls  = pick;
            m_last = pick;
            m_word = fq[pick][0];
         end
      end else if (m_age < 2) begin
         m_age++;
      end else if (out_ready) begin
         m_busy       = 0;
         m_cnt[m_cls] = (m_cnt[m_cls] + 1) % 32;
      end
      m_cv = nxt_cv;
      m_co = nxt_co;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rd_prev[i] && fq[i].size() > 0) din[i] = fq[i].pop_front();
         else din[i] = W'($urandom);
      end
      refresh_empty();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_val("rst_fifo_rd", 32'(fifo_rd), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      check_val("rst_out_class", 32'(out_class), 32'd0);
      check_val("rst_count_valid", 32'(count_valid), 32'd0);
      check_val("rst_count_out", 32'(count_out), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      bit done;
      done = 0;
      for (int c = 0; c < budget && !done; c++) begin
         tick();
         done = !m_busy && fq[0].size() == 0 && fq[1].size() == 0 &&
                fq[2].size() == 0 && fq[3].size() == 0;
      end
      check_val("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      int  seq[$];
      int  at[$];
      bit  found;
      reset     = 1'b0;
      enable    = 1'b0;
      out_ready = 1'b1;
      count_req = 1'b0;
      count_idx = 2'd0;
      foreach (din[i]) din[i] = '0;
      refresh_empty();
      model_reset();
      #6;
      do_reset();

      // Single word from FIFO 2: strobe next cycle, valid two cycles later, idle after.
      enable = 1'b1;
      push(2, 10'h155);
      tick();
      check_val("lat_rd", 32'(fifo_rd), 32'h4);
      tick();
      tick();
      check_val("lat_valid", 32'(out_valid), 32'd1);
      check_val("lat_data", 32'(out_data), 32'h155);
      check_val("lat_class", 32'(out_class), 32'd2);
      tick();
      check_val("lat_idle", 32'(idle_out), 32'd1);

      // All four FIFOs busy after reset: grants 0,1,2,3,0 spaced four cycles apart.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(i, W'($urandom));
         push(i, W'($urandom));
      end
      for (int c = 0; c < 22; c++) begin
         tick();
         if (fifo_rd != 4'h0) begin
            seq.push_back($clog2(fifo_rd));
            at.push_back(c);
         end
      end
      check_val("rr_count_ok", 32'(seq.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < seq.size(); k++) begin
         check_val("rr_order", 32'(seq[k]), 32'(k % 4));
         if (k > 0) check_val("rr_spacing", 32'(at[k] - at[k-1]), 32'd4);
      end
      drain(60);

      // Backpressure: out_ready low for several hold cycles.
      push(1, W'($urandom));
      push(0, W'($urandom));
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      out_ready = 1'b1;
      drain(20);

      // Enable dropped in the read cycle: word completes, then no further reads.
      push(3, W'($urandom));
      push(3, W'($urandom));
      enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      enable = 1'b1;
      drain(20);

      // Reset while the word is being captured; priority restarts at FIFO 0.
      for (int i = 0; i < 4; i++) push(i, W'($urandom));
      tick();
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         found = m_busy && m_age == 1;
      end
      check_val("rst_setup", 32'(found), 32'd1);
      do_reset();
      push(0, W'($urandom));
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         found = (fifo_rd != 4'h0);
      end
      check_val("rst_resume", 32'(fifo_rd), 32'h1);
      drain(60);

      // 33 words from class 1 wrap its counter to 1.
      do_reset();
      for (int n = 0; n < 33; n++) push(1, W'($urandom));
      drain(200);
      count_req = 1'b1;
      count_idx = 2'd1;
      tick();
      count_req = 1'b0;
`ifdef EGRESS_COUNT_EN
      check_val("cnt_wrap_valid", 32'(count_valid), 32'd1);
      check_val("cnt_wrap_value", 32'(count_out), 32'd1);
`else
      check_val("cnt_off_valid", 32'(count_valid), 32'd0);
      check_val("cnt_off_value", 32'(count_out), 32'd0);
`endif
      tick();

      // Random traffic with occasional reset.
      for (int c = 0; c < 600; c++) begin
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         count_req = $urandom_range(0, 1) == 1;
         count_idx = 2'($urandom);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 5) == 0 && fq[i].size() < 6) push(i, W'($urandom));
         end
         if ($urandom_range(0, 199) == 0) do_reset();
         else tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
